// File: rtl/sensor_packet_parser.sv
// -----------------------------------------------------------------------------
// sensor_packet_parser
//
// Purpose
//   Watches a 16-byte sensor packet buffer (written by an SPI slave in the same
//   clock domain) and turns a stable, newly changed packet into registered
//   attitude/rate fields. A round-robin scanner compares one byte per cycle
//   against a shadow copy. A packet decodes only after one full pass has seen a
//   change and a later full pass has seen none. This keeps a buffer that is
//   still being written from ever being decoded half-old/half-new.
//
// Optional build macro
//   PARSER_STALE_TIMEOUT_EN : when defined, builds a saturating cycle counter
//   that raises 'stale' once STALE_CYCLES cycles pass without a good packet.
//   When undefined, no counter exists and 'stale' is tied low.
//
// Parameters
//   STALE_CYCLES : cycles without a good packet before 'stale' asserts
//                  (only meaningful with PARSER_STALE_TIMEOUT_EN).
//
// Ports
//   clk            in   system clock (single clock domain)
//   reset          in   asynchronous, active-high reset
//   packet_in      in   8 x [0:15] raw packet bytes, byte 0 is the header
//   roll/pitch/yaw out  signed 16, Euler angles x100, bytes {1,2}/{3,4}/{5,6}
//   gyro_x/y/z     out  signed 16, rates x2000, bytes {7,8}/{9,10}/{11,12}
//   flags          out  8, packet byte 13
//   sample_valid   out  one-cycle pulse when the field outputs update
//   header_err     out  one-cycle pulse when a packet is rejected (header!=0xAA)
//   packet_count   out  16, good packets, wraps
//   err_count      out  8, bad-header packets, saturates at 255
//   stale          out  no good packet within STALE_CYCLES
// -----------------------------------------------------------------------------
module sensor_packet_parser #(
  parameter int STALE_CYCLES = 4_800_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         packet_in [0:15],
  output logic signed [15:0] roll,
  output logic signed [15:0] pitch,
  output logic signed [15:0] yaw,
  output logic signed [15:0] gyro_x,
  output logic signed [15:0] gyro_y,
  output logic signed [15:0] gyro_z,
  output logic [7:0]         flags,
  output logic               sample_valid,
  output logic               header_err,
  output logic [15:0]        packet_count,
  output logic [7:0]         err_count,
  output logic               stale
);

  localparam logic [7:0] HEADER = 8'hAA;

  typedef enum logic {
    ST_SCAN   = 1'b0,
    ST_DECODE = 1'b1
  } state_t;

  // Elaboration-time sanity check on the timeout length.
  if (STALE_CYCLES < 1) begin : g_bad_stale_cycles
    $error("STALE_CYCLES must be at least 1");
  end

  // Big-endian byte pair to a signed 16-bit field.
  function automatic logic signed [15:0] field16(input logic [7:0] msb,
                                                 input logic [7:0] lsb);
    return $signed({msb, lsb});
  endfunction

  // Increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_shadow [0:15];
  logic [3:0]        r_idx;
  logic              r_dirty;
  logic              r_pending;

  logic              w_byte_diff;
  logic              w_pass_end;
  logic              w_dirty_any;
  logic              w_scan;
  logic              w_decode;
  logic              w_hdr_ok;

  logic              r_good_p0;
  logic              r_bad_p0;

  logic signed [15:0] r_roll;
  logic signed [15:0] r_pitch;
  logic signed [15:0] r_yaw;
  logic signed [15:0] r_gyro_x;
  logic signed [15:0] r_gyro_y;
  logic signed [15:0] r_gyro_z;
  logic [7:0]         r_flags;
  logic               r_sample_valid;
  logic               r_header_err;
  logic [15:0]        r_packet_count;
  logic [7:0]         r_err_count;

  // Byte under the scan pointer differs from its shadow copy.
  assign w_byte_diff = (packet_in[r_idx] != r_shadow[r_idx]);
  assign w_pass_end  = (r_idx == 4'd15);
  // Dirty status of the pass including the byte being scanned right now.
  assign w_dirty_any = r_dirty | w_byte_diff;
  assign w_hdr_ok    = (r_shadow[0] == HEADER);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_SCAN: begin
        // Decode only after a change was latched (pending) and a whole pass
        // since then has found every byte unchanged.
        if (w_pass_end && !w_dirty_any && r_pending) begin
          w_state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        w_state_nxt = ST_SCAN;
      end
      default: begin
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_scan   = 1'b0;
    w_decode = 1'b0;
    unique case (r_state)
      ST_SCAN:   w_scan   = 1'b1;
      ST_DECODE: w_decode = 1'b1;
      default:   w_scan   = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scanner: shadow copy, scan index, dirty/pending tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_shadow[i] <= 8'h00;
      end
      r_idx     <= 4'd0;
      r_dirty   <= 1'b0;
      r_pending <= 1'b0;
    end else if (w_scan) begin
      r_shadow[r_idx] <= packet_in[r_idx];
      r_idx           <= r_idx + 4'd1;
      if (w_pass_end) begin
        // A dirty pass re-arms pending; a clean pass leaves it as is so that
        // the transition to DECODE above can consume it.
        r_dirty <= 1'b0;
        if (w_dirty_any) begin
          r_pending <= 1'b1;
        end
      end else begin
        r_dirty <= w_dirty_any;
      end
    end else if (w_decode) begin
      r_pending <= 1'b0;
      r_idx     <= 4'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: header verdict captured in the DECODE cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_good_p0 <= 1'b0;
      r_bad_p0  <= 1'b0;
    end else begin
      r_good_p0 <= w_decode & w_hdr_ok;
      r_bad_p0  <= w_decode & ~w_hdr_ok;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: field registers, pulses and counters
  // ---------------------------------------------------------------------------
  // Only shadow[0] can be rewritten on the edge that loads these fields
  // (the scanner restarts at index 0), so bytes 1..13 are still the
  // decoded packet here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_roll         <= '0;
      r_pitch        <= '0;
      r_yaw          <= '0;
      r_gyro_x       <= '0;
      r_gyro_y       <= '0;
      r_gyro_z       <= '0;
      r_flags        <= '0;
      r_sample_valid <= 1'b0;
      r_header_err   <= 1'b0;
      r_packet_count <= '0;
      r_err_count    <= '0;
    end else begin
      r_sample_valid <= r_good_p0;
      r_header_err   <= r_bad_p0;
      if (r_good_p0) begin
        r_roll         <= field16(r_shadow[1],  r_shadow[2]);
        r_pitch        <= field16(r_shadow[3],  r_shadow[4]);
        r_yaw          <= field16(r_shadow[5],  r_shadow[6]);
        r_gyro_x       <= field16(r_shadow[7],  r_shadow[8]);
        r_gyro_y       <= field16(r_shadow[9],  r_shadow[10]);
        r_gyro_z       <= field16(r_shadow[11], r_shadow[12]);
        r_flags        <= r_shadow[13];
        r_packet_count <= r_packet_count + 16'd1;
      end
      if (r_bad_p0) begin
        r_err_count <= sat_inc8(r_err_count);
      end
    end
  end

  assign roll         = r_roll;
  assign pitch        = r_pitch;
  assign yaw          = r_yaw;
  assign gyro_x       = r_gyro_x;
  assign gyro_y       = r_gyro_y;
  assign gyro_z       = r_gyro_z;
  assign flags        = r_flags;
  assign sample_valid = r_sample_valid;
  assign header_err   = r_header_err;
  assign packet_count = r_packet_count;
  assign err_count    = r_err_count;

`ifdef PARSER_STALE_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(STALE_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_CYCLES);

  logic [CNT_W-1:0] r_stale_cnt;

  // Starts saturated so the output reads stale until the first good packet.
  // Clearing on the same edge that raises sample_valid drops stale in the
  // pulse cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stale_cnt <= STALE_MAX;
    end else if (r_good_p0) begin
      r_stale_cnt <= '0;
    end else if (r_stale_cnt != STALE_MAX) begin
      r_stale_cnt <= r_stale_cnt + CNT_W'(1);
    end
  end

  assign stale = (r_stale_cnt == STALE_MAX);
`else
  assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_packet_parser.sv
module tb_sensor_packet_parser;

  localparam int STALE = 100;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [7:0]         pkt [0:15];
  logic signed [15:0] roll, pitch, yaw, gyro_x, gyro_y, gyro_z;
  logic [7:0]         flags;
  logic               sample_valid, header_err;
  logic [15:0]        packet_count;
  logic [7:0]         err_count;
  logic               stale;

  sensor_packet_parser #(.STALE_CYCLES(STALE)) dut (
    .clk(clk), .reset(reset), .packet_in(pkt),
    .roll(roll), .pitch(pitch), .yaw(yaw),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .flags(flags), .sample_valid(sample_valid), .header_err(header_err),
    .packet_count(packet_count), .err_count(err_count), .stale(stale)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: works pass by pass on the packet stream.
  // ---------------------------------------------------------------------------
  logic [7:0]         m_shadow [0:15];
  bit                 m_pending;
  int                 m_cnt;
  bit                 e_sv, e_he;
  logic signed [15:0] e_roll, e_pitch, e_yaw, e_gx, e_gy, e_gz;
  logic [7:0]         e_flags, e_ec;
  logic [15:0]        e_pc;

  task automatic m_clear();
    for (int i = 0; i < 16; i++) m_shadow[i] = 8'h00;
    m_pending = 0; m_cnt = STALE;
    e_sv = 0; e_he = 0; e_pc = 0; e_ec = 0; e_flags = 0;
    e_roll = 0; e_pitch = 0; e_yaw = 0; e_gx = 0; e_gy = 0; e_gz = 0;
  endtask

  task automatic m_step(output bit ab);
    @(posedge clk);
    e_sv = 0; e_he = 0;
    if (reset) begin
      m_clear();
      ab = 1;
    end else begin
      ab = 0;
      if (m_cnt < STALE) m_cnt++;
    end
  endtask

  initial begin : model
    bit ab, reuse, changed, hdr_ok;
    m_clear();
    forever begin
      ab = 0; reuse = 0;
      while (!ab) begin
        changed = 0;
        for (int i = 0; i < 16; i++) begin
          if (!(i == 0 && reuse)) begin
            m_step(ab);
            if (ab) break;
          end
          if (pkt[i] != m_shadow[i]) changed = 1;
          m_shadow[i] = pkt[i];
        end
        reuse = 0;
        if (ab) break;
        if (changed) begin
          m_pending = 1;
        end else if (m_pending) begin
          m_step(ab);                         // decode cycle
          if (ab) break;
          m_pending = 0;
          hdr_ok = (m_shadow[0] == 8'hAA);
          m_step(ab);                         // results appear; also scans byte 0
          if (ab) break;
          if (hdr_ok) begin
            e_roll  = $signed({m_shadow[1],  m_shadow[2]});
            e_pitch = $signed({m_shadow[3],  m_shadow[4]});
            e_yaw   = $signed({m_shadow[5],  m_shadow[6]});
            e_gx    = $signed({m_shadow[7],  m_shadow[8]});
            e_gy    = $signed({m_shadow[9],  m_shadow[10]});
            e_gz    = $signed({m_shadow[11], m_shadow[12]});
            e_flags = m_shadow[13];
            e_pc    = e_pc + 16'd1;
            e_sv    = 1;
            m_cnt   = 0;
          end else begin
            e_he = 1;
            if (e_ec != 8'hFF) e_ec = e_ec + 8'd1;
          end
          reuse = 1;
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("sample_valid", int'(sample_valid), int'(e_sv));
      chk("header_err", int'(header_err), int'(e_he));
      chk("sv_he_exclusive", int'(sample_valid & header_err), 0);
      chk("roll", int'(roll), int'(e_roll));
      chk("pitch", int'(pitch), int'(e_pitch));
      chk("yaw", int'(yaw), int'(e_yaw));
      chk("gyro_x", int'(gyro_x), int'(e_gx));
      chk("gyro_y", int'(gyro_y), int'(e_gy));
      chk("gyro_z", int'(gyro_z), int'(e_gz));
      chk("flags", int'(flags), int'(e_flags));
      chk("packet_count", int'(packet_count), int'(e_pc));
      chk("err_count", int'(err_count), int'(e_ec));
`ifdef PARSER_STALE_TIMEOUT_EN
      chk("stale", int'(stale), int'(m_cnt == STALE));
`else
      chk("stale", int'(stale), 0);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_pkt(input logic [127:0] p);
    for (int i = 0; i < 16; i++) pkt[i] = p[127-8*i -: 8];
  endtask

  task automatic reset_with(input logic [127:0] p);
    @(negedge clk);
    reset = 1'b1;
    set_pkt(p);
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_count(input int n, output int nsv, output int nhe);
    nsv = 0; nhe = 0;
    repeat (n) begin
      @(negedge clk);
      if (sample_valid) nsv++;
      if (header_err) nhe++;
    end
  endtask

  // kind: 0 = none within budget, 1 = sample_valid, 2 = header_err
  task automatic wait_pulse(input int maxc, output int kind, output int k);
    kind = 0;
    for (k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (sample_valid) begin kind = 1; break; end
      if (header_err)   begin kind = 2; break; end
    end
  endtask

  typedef struct {
    logic [127:0] pk;
    int kind;
    int roll, pitch, yaw, gx, gy, gz, flags, pc, ec;
  } vec_t;

  vec_t tbl [6];

  localparam logic [127:0] P1 = 128'hAA00_64FF_3846_5007_D0F8_3000_0005_0000;

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int kind, k, nsv, nhe, hdr_pulses;
    logic [127:0] p;
    int hold, pos;

    tbl[0] = '{pk: P1, kind: 1, roll: 100, pitch: -200, yaw: 18000, gx: 2000,
               gy: -2000, gz: 0, flags: 5, pc: 1, ec: 0};
    tbl[1] = '{pk: 128'h5500_64FF_3846_5007_D0F8_3000_0005_0000, kind: 2, roll: 100,
               pitch: -200, yaw: 18000, gx: 2000, gy: -2000, gz: 0, flags: 5, pc: 1, ec: 1};
    tbl[2] = '{pk: 128'hAA7F_FF80_0000_01FF_FF00_0012_34A5_EEEE, kind: 1, roll: 32767,
               pitch: -32768, yaw: 1, gx: -1, gy: 0, gz: 4660, flags: 165, pc: 2, ec: 1};
    tbl[3] = '{pk: 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, kind: 2, roll: 32767,
               pitch: -32768, yaw: 1, gx: -1, gy: 0, gz: 4660, flags: 165, pc: 2, ec: 2};
    tbl[4] = '{pk: 128'hAA80_017F_FE12_3480_007F_FF00_01FF_0000, kind: 1, roll: -32767,
               pitch: 32766, yaw: 4660, gx: -32768, gy: 32767, gz: 1, flags: 255, pc: 3, ec: 2};
    tbl[5] = '{pk: 128'hAB80_017F_FE12_3480_007F_FF00_01FF_0000, kind: 2, roll: -32767,
               pitch: 32766, yaw: 4660, gx: -32768, gy: 32767, gz: 1, flags: 255, pc: 3, ec: 3};

    // Reset values, observed while reset is held.
    set_pkt('0);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_roll", int'(roll), 0);
    chk("rst_gyro_z", int'(gyro_z), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_header_err", int'(header_err), 0);
    chk("rst_packet_count", int'(packet_count), 0);
    chk("rst_err_count", int'(err_count), 0);
`ifdef PARSER_STALE_TIMEOUT_EN
    chk("rst_stale", int'(stale), 1);
`else
    chk("rst_stale", int'(stale), 0);
`endif
    chk_en = 1'b1;
    reset = 1'b0;

    // All-zero packet after reset never decodes.
    run_count(60, nsv, nhe);
    chk("zero_pkt_pulses", nsv + nhe, 0);

    // Reset in the middle of a pass aborts silently.
    reset_with(P1);
    run_count(20, nsv, nhe);
    chk("midpass_pulses", nsv + nhe, 0);

    // Reset while the decode cycle is in progress aborts silently.
    reset_with(P1);
    run_count(32, nsv, nhe);
    reset = 1'b1;
    run_count(3, nsv, nhe);
    chk("decode_abort_pulses", nsv + nhe, 0);
    reset = 1'b0;

    // Table of packets; the first one also measures latency from pass start.
    for (int v = 0; v < 6; v++) begin
      if (v == 0) begin
        reset_with(tbl[v].pk);
      end else begin
        @(negedge clk);
        set_pkt(tbl[v].pk);
      end
      wait_pulse(80, kind, k);
      if (v == 0) chk("latency_cycles", k, 34);
      chk($sformatf("v%0d_kind", v), kind, tbl[v].kind);
      chk($sformatf("v%0d_roll", v), int'(roll), tbl[v].roll);
      chk($sformatf("v%0d_pitch", v), int'(pitch), tbl[v].pitch);
      chk($sformatf("v%0d_yaw", v), int'(yaw), tbl[v].yaw);
      chk($sformatf("v%0d_gyro_x", v), int'(gyro_x), tbl[v].gx);
      chk($sformatf("v%0d_gyro_y", v), int'(gyro_y), tbl[v].gy);
      chk($sformatf("v%0d_gyro_z", v), int'(gyro_z), tbl[v].gz);
      chk($sformatf("v%0d_flags", v), int'(flags), tbl[v].flags);
      chk($sformatf("v%0d_packet_count", v), int'(packet_count), tbl[v].pc);
      chk($sformatf("v%0d_err_count", v), int'(err_count), tbl[v].ec);
    end

    // Holding one packet for ten passes yields a single decode.
    @(negedge clk);
    set_pkt(P1);
    run_count(160, nsv, nhe);
    chk("hold10_sv", nsv, 1);
    chk("hold10_he", nhe, 0);

    // Rewriting identical contents is not a new packet.
    set_pkt(P1);
    run_count(60, nsv, nhe);
    chk("resend_pulses", nsv + nhe, 0);

    // Byte 5 keeps changing (interval shorter than a pass) -> no decode until
    // it settles, then one decode carrying the final value.
    nsv = 0; nhe = 0;
    for (int c = 0; c < 200; c++) begin
      if (c % 12 == 0) pkt[5] = 8'h10 + 8'(c / 12);
      @(negedge clk);
      if (sample_valid) nsv++;
      if (header_err) nhe++;
    end
    chk("changing_pulses", nsv + nhe, 0);
    wait_pulse(80, kind, k);
    chk("settled_kind", kind, 1);
    chk("settled_yaw", int'(yaw), 16'sh2050);
    run_count(60, nsv, nhe);
    chk("settled_extra_pulses", nsv + nhe, 0);

    // 300 rejected packets: err_count sticks at 255.
    hdr_pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      set_pkt({8'h55, 8'(i), 112'h0});
      wait_pulse(80, kind, k);
      if (kind == 2) hdr_pulses++;
    end
    chk("bad_hdr_pulses", hdr_pulses, 300);
    chk("err_count_sat", int'(err_count), 255);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      p = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) p[127:120] = 8'hAA;
      set_pkt(p);
      hold = $urandom_range(4, 70);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (h == hold / 2 && $urandom_range(0, 3) == 0) begin
          pos = $urandom_range(0, 15);
          pkt[pos] = 8'($urandom);
        end
      end
    end
    repeat (80) @(negedge clk);

`ifdef PARSER_STALE_TIMEOUT_EN
    @(negedge clk);
    set_pkt(tbl[2].pk ^ 128'h0000_0000_0000_0000_0000_0000_0000_0101);
    wait_pulse(80, kind, k);
    chk("stale_decode_kind", kind, 1);
    chk("stale_at_sv", int'(stale), 0);
    repeat (99) @(negedge clk);
    chk("stale_before_timeout", int'(stale), 0);
    @(negedge clk);
    chk("stale_at_timeout", int'(stale), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
